// File: rtl/convolution_index_seq.sv
`default_nettype none
// convolution_index_seq: walks output index n and inner index k of a direct-form
// convolution, issuing (x[k], y[n-k], z[n]) terms with first/last-of-sum flags.
module convolution_index_seq #(
  parameter int DATAWIDTH = 5
) (
  input  logic                 clk,
  input  logic                 rsth,
  input  logic                 starth,
  input  logic [DATAWIDTH-1:0] size_x,
  input  logic [DATAWIDTH-1:0] size_y,
  input  logic                 readyh,
  output logic                 valid_o,
  output logic [DATAWIDTH-1:0] addr_x,
  output logic [DATAWIDTH-1:0] addr_y,
  output logic [DATAWIDTH:0]   addr_z,
  output logic                 first_o,
  output logic                 last_o,
  output logic                 busy_o,
  output logic                 done_o
);

  localparam logic [DATAWIDTH:0]   C_N_ONE = (DATAWIDTH+1)'(1);
  localparam logic [DATAWIDTH:0]   C_N_TWO = (DATAWIDTH+1)'(2);
  localparam logic [DATAWIDTH-1:0] C_K_ONE = DATAWIDTH'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               r_state;
  logic [DATAWIDTH-1:0] r_nx;
  logic [DATAWIDTH-1:0] r_ny;
  logic [DATAWIDTH:0]   r_n;
  logic [DATAWIDTH-1:0] r_k;
  logic [DATAWIDTH-1:0] r_ay;
  logic                 r_valid;
  logic                 r_first;
  logic                 r_last;
  logic                 r_busy;
  logic                 r_done;

  logic [DATAWIDTH:0]   w_nxm1;
  logic [DATAWIDTH:0]   w_nym1;
  logic [DATAWIDTH:0]   w_nlast;
  logic [DATAWIDTH:0]   w_n1;
  logic [DATAWIDTH:0]   w_kend;
  logic [DATAWIDTH:0]   w_kstart1;
  logic [DATAWIDTH:0]   w_kend1;
  logic [DATAWIDTH-1:0] w_k1;

  // Bounds are evaluated one bit wider than the sizes so Nx+Ny-2 never wraps.
  assign w_nxm1    = {1'b0, r_nx} - C_N_ONE;
  assign w_nym1    = {1'b0, r_ny} - C_N_ONE;
  assign w_nlast   = {1'b0, r_nx} + {1'b0, r_ny} - C_N_TWO;
  assign w_n1      = r_n + C_N_ONE;
  assign w_k1      = r_k + C_K_ONE;
  assign w_kend    = (r_n < w_nxm1) ? r_n : w_nxm1;
  assign w_kstart1 = (w_n1 > w_nym1) ? (w_n1 - w_nym1) : '0;
  assign w_kend1   = (w_n1 < w_nxm1) ? w_n1 : w_nxm1;

  always_ff @(posedge clk or posedge rsth) begin
    if (rsth) begin
      r_state <= S_IDLE;
      r_nx    <= '0;
      r_ny    <= '0;
      r_n     <= '0;
      r_k     <= '0;
      r_ay    <= '0;
      r_valid <= 1'b0;
      r_first <= 1'b0;
      r_last  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (starth) begin
            r_nx <= size_x;
            r_ny <= size_y;
            r_n  <= '0;
            r_k  <= '0;
            r_ay <= '0;
            if ((size_x == '0) || (size_y == '0)) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              // Sum 0 always has exactly one term, so it is both first and last.
              r_state <= S_RUN;
              r_valid <= 1'b1;
              r_busy  <= 1'b1;
              r_first <= 1'b1;
              r_last  <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (readyh) begin
            if ({1'b0, r_k} < w_kend) begin
              r_k     <= w_k1;
              r_ay    <= r_ay - C_K_ONE;
              r_first <= 1'b0;
              r_last  <= ({1'b0, w_k1} == w_kend);
            end else if (r_n == w_nlast) begin
              r_state <= S_DONE;
              r_n     <= '0;
              r_k     <= '0;
              r_ay    <= '0;
              r_valid <= 1'b0;
              r_busy  <= 1'b0;
              r_first <= 1'b0;
              r_last  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_n     <= w_n1;
              r_k     <= DATAWIDTH'(w_kstart1);
              r_ay    <= DATAWIDTH'(w_n1 - w_kstart1);
              r_first <= 1'b1;
              r_last  <= (w_kstart1 == w_kend1);
            end
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign valid_o = r_valid;
  assign addr_x  = r_k;
  assign addr_y  = r_ay;
  assign addr_z  = r_n;
  assign first_o = r_first;
  assign last_o  = r_last;
  assign busy_o  = r_busy;
  assign done_o  = r_done;

endmodule
`default_nettype wire

// File: tb/tb_convolution_index_seq.sv
`default_nettype none
// Testbench for convolution_index_seq: scoreboard of expected (z,x,y,first,last)
// terms built from the index bounds, compared as the DUT offers each term.
module tb_convolution_index_seq;
  localparam int DW = 5;

  typedef struct packed {
    logic [DW:0]   z;
    logic [DW-1:0] x;
    logic [DW-1:0] y;
    logic          f;
    logic          l;
  } term_t;

  logic          clk = 1'b0;
  logic          rsth;
  logic          starth;
  logic [DW-1:0] size_x;
  logic [DW-1:0] size_y;
  logic          readyh;
  logic          valid_o;
  logic [DW-1:0] addr_x;
  logic [DW-1:0] addr_y;
  logic [DW:0]   addr_z;
  logic          first_o;
  logic          last_o;
  logic          busy_o;
  logic          done_o;

  int    tests = 0;
  int    fails = 0;
  term_t q[$];

  convolution_index_seq #(.DATAWIDTH(DW)) dut (
    .clk(clk), .rsth(rsth), .starth(starth), .size_x(size_x), .size_y(size_y),
    .readyh(readyh), .valid_o(valid_o), .addr_x(addr_x), .addr_y(addr_y),
    .addr_z(addr_z), .first_o(first_o), .last_o(last_o), .busy_o(busy_o),
    .done_o(done_o)
  );

  always #5 clk = ~clk;

  task automatic build_model(input int nx, input int ny);
    term_t t;
    int ks, ke;
    q.delete();
    if (nx == 0 || ny == 0) return;
    for (int n = 0; n <= nx + ny - 2; n++) begin
      ks = (n > ny - 1) ? n - (ny - 1) : 0;
      ke = (n < nx - 1) ? n : nx - 1;
      for (int k = ks; k <= ke; k++) begin
        t.z = (DW+1)'(n);
        t.x = DW'(k);
        t.y = DW'(n - k);
        t.f = (k == ks);
        t.l = (k == ke);
        q.push_back(t);
      end
    end
  endtask

  task automatic test_reset();
    rsth = 1'b1; starth = 1'b0; readyh = 1'b1; size_x = '0; size_y = '0;
    repeat (3) @(negedge clk);
    tests++;
    if ({valid_o, addr_x, addr_y, addr_z, first_o, last_o, busy_o, done_o} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got v=%b x=%0d y=%0d z=%0d f=%b l=%b busy=%b done=%b, want all 0",
               valid_o, addr_x, addr_y, addr_z, first_o, last_o, busy_o, done_o);
    end
    rsth = 1'b0;
    @(negedge clk);
  endtask

  // stall_idx/stall_len hold readyh low on one term; rnd randomises readyh instead.
  task automatic test_sequence(input string name, input int nx, input int ny,
                               input int stall_idx, input int stall_len, input bit rnd);
    int    cyc, stalls, acc, held, exp_done;
    bit    seen_done;
    term_t o, e;
    build_model(nx, ny);
    @(negedge clk);
    size_x = DW'(nx); size_y = DW'(ny); starth = 1'b1; readyh = 1'b1;
    cyc = 0; stalls = 0; acc = 0; held = 0; seen_done = 1'b0;
    while (!seen_done && cyc < nx * ny * 4 + 20) begin
      @(negedge clk);
      cyc++;
      starth = 1'($urandom_range(0, 1));
      size_x = DW'($urandom);
      size_y = DW'($urandom);
      tests++;
      if (busy_o !== valid_o) begin
        fails++;
        $display("FAIL %s busy_vs_valid cyc %0d: busy=%b valid=%b, want equal", name, cyc, busy_o, valid_o);
      end
      if (done_o === 1'b1) begin
        seen_done = 1'b1;
        tests++;
        if (valid_o !== 1'b0) begin
          fails++;
          $display("FAIL %s valid_in_done: got %b want 0", name, valid_o);
        end
      end else if (valid_o === 1'b1) begin
        o = '{addr_z, addr_x, addr_y, first_o, last_o};
        tests++;
        if (q.size() == 0) begin
          fails++;
          $display("FAIL %s extra_term cyc %0d: got z=%0d x=%0d y=%0d, want no term", name, cyc, o.z, o.x, o.y);
        end else begin
          e = q[0];
          if (o !== e) begin
            fails++;
            $display("FAIL %s term%0d: got z=%0d x=%0d y=%0d f=%b l=%b, want z=%0d x=%0d y=%0d f=%b l=%b",
                     name, acc, o.z, o.x, o.y, o.f, o.l, e.z, e.x, e.y, e.f, e.l);
          end
          if (acc == 0) begin
            tests++;
            if (cyc != 1) begin
              fails++;
              $display("FAIL %s first_valid_cycle: got %0d want 1", name, cyc);
            end
          end
          if (rnd) readyh = ($urandom_range(0, 3) != 0);
          else     readyh = !(acc == stall_idx && held < stall_len);
          if (readyh) begin
            void'(q.pop_front());
            acc++;
          end else begin
            stalls++;
            held++;
          end
        end
      end
    end
    starth = 1'b0;
    readyh = 1'b1;
    tests++;
    if (!seen_done) begin
      fails++;
      $display("FAIL %s done_timeout: got no done_o within %0d cycles, want done_o", name, cyc);
    end
    exp_done = (nx * ny == 0) ? 1 : nx * ny + stalls + 1;
    tests++;
    if (cyc != exp_done) begin
      fails++;
      $display("FAIL %s done_cycle: got %0d want %0d", name, cyc, exp_done);
    end
    tests++;
    if (acc != nx * ny) begin
      fails++;
      $display("FAIL %s term_count: got %0d want %0d", name, acc, nx * ny);
    end
    @(negedge clk);
    tests++;
    if ({valid_o, busy_o, done_o} !== 3'b000) begin
      fails++;
      $display("FAIL %s idle_after_done: got v=%b busy=%b done=%b, want 000", name, valid_o, busy_o, done_o);
    end
  endtask

  task automatic test_abort();
    @(negedge clk);
    size_x = 5'd3; size_y = 5'd2; starth = 1'b1; readyh = 1'b1;
    @(negedge clk);
    starth = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if ({valid_o, addr_z, addr_x, addr_y} !== {1'b1, 6'd2, 5'd1, 5'd1}) begin
      fails++;
      $display("FAIL abort_term4: got v=%b z=%0d x=%0d y=%0d, want v=1 z=2 x=1 y=1", valid_o, addr_z, addr_x, addr_y);
    end
    #2 rsth = 1'b1;
    #1;
    tests++;
    if ({valid_o, addr_x, addr_y, addr_z, first_o, last_o, busy_o, done_o} !== '0) begin
      fails++;
      $display("FAIL abort_async_clear: got v=%b x=%0d y=%0d z=%0d f=%b l=%b busy=%b done=%b, want all 0",
               valid_o, addr_x, addr_y, addr_z, first_o, last_o, busy_o, done_o);
    end
    @(negedge clk);
    rsth = 1'b0;
    repeat (3) begin
      @(negedge clk);
      tests++;
      if ({valid_o, busy_o, done_o} !== 3'b000) begin
        fails++;
        $display("FAIL abort_no_done: got v=%b busy=%b done=%b, want 000", valid_o, busy_o, done_o);
      end
    end
  endtask

  initial begin
    test_reset();
    test_sequence("basic_3x2", 3, 2, -1, 0, 1'b0);
    test_sequence("single_1x1", 1, 1, -1, 0, 1'b0);
    test_sequence("zero_0x4", 0, 4, -1, 0, 1'b0);
    test_sequence("zero_4x0", 4, 0, -1, 0, 1'b0);
    test_sequence("stall_3x2", 3, 2, 2, 3, 1'b0);
    test_sequence("back_to_back_2x5", 2, 5, -1, 0, 1'b0);
    test_sequence("back_to_back_5x3", 5, 3, -1, 0, 1'b1);
    test_sequence("max_31x31", 31, 31, -1, 0, 1'b1);
    test_abort();
    test_sequence("restart_2x2", 2, 2, -1, 0, 1'b0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
`default_nettype wire
